// File: rtl/rv_pkg.sv
// Shared definitions for the writeback path: load funct3 encodings,
// data width, and the small records passed between selection and buffer.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Which channel owns the register file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LD   = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_ALU  = 2'd3
    } src_e;

    // A pending register file write: destination and value.
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data formatter: picks the addressed byte or halfword
// out of the raw memory word and sign- or zero-extends it. Unsupported
// funct3 values pass the raw word through and raise err.
module load_align
    import rv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte lane and halfword lane.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane according to the load type.
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        data = rdata;
        err  = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = rdata;
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: merges ALU results and load responses onto the single
// register file write port. Loads always win; an ALU result that collides
// with a load is parked in a one-entry buffer and written on the next
// load-free cycle. All write-port outputs are registered.
module wb_unit
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    output logic            wb_en,
    output logic [4:0]      rd_index,
    output logic [XLEN-1:0] wb_data,
    output logic            ld_err
);

    logic            buf_valid;
    wb_entry_t       buf_q;
    logic            buf_valid_d;
    wb_entry_t       buf_d;
    src_e            src;
    wb_entry_t       sel;
    logic            wr_go;
    logic            alu_fire;
    logic [XLEN-1:0] ld_data;
    logic            ld_bad;

    assign alu_ready = !buf_valid;
    assign ld_ready  = 1'b1;
    assign alu_fire  = alu_valid && alu_ready;

    load_align u_load_align (
        .funct3  (ld_funct3),
        .addr_lo (ld_addr_lo),
        .rdata   (ld_rdata),
        .data    (ld_data),
        .err     (ld_bad)
    );

    // Pick the writer for this cycle (load > buffer > ALU) and work out the
    // buffer's next contents.
    always_comb begin
        src         = SRC_NONE;
        sel         = '0;
        buf_valid_d = buf_valid;
        buf_d       = buf_q;
        if (ld_valid) begin
            src      = SRC_LD;
            sel.rd   = ld_rd;
            sel.data = ld_data;
            if (alu_fire) begin
                buf_valid_d = 1'b1;
                buf_d.rd    = alu_rd;
                buf_d.data  = alu_data;
            end
        end else if (buf_valid) begin
            src         = SRC_BUF;
            sel         = buf_q;
            buf_valid_d = 1'b0;
        end else if (alu_fire) begin
            src      = SRC_ALU;
            sel.rd   = alu_rd;
            sel.data = alu_data;
        end
    end

    // x0 writes are consumed but never reach the register file.
    assign wr_go = (src != SRC_NONE) && (sel.rd != 5'd0);

    // Buffer occupancy; reset drops any parked result.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
        end else begin
            buf_valid <= buf_valid_d;
        end
    end

    // Buffer payload, loaded only when an ALU result is parked.
    // NOTE: the payload is not reset; it is meaningless while buf_valid is
    // low, so a reset here would only add routing for no functional gain.
    always_ff @(posedge clk) begin
        if (ld_valid && alu_fire) begin
            buf_q <= buf_d;
        end
    end

    // Registered write port; index and data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en    <= 1'b0;
            ld_err   <= 1'b0;
            rd_index <= 5'd0;
            wb_data  <= '0;
        end else begin
            wb_en  <= wr_go;
            ld_err <= wr_go && (src == SRC_LD) && ld_bad;
            if (wr_go) begin
                rd_index <= sel.rd;
                wb_data  <= sel.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed vector table, hand-written
// collision/starvation/reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_wb_unit;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_rdata;
    logic        wb_en;
    logic [4:0]  rd_index;
    logic [31:0] wb_data;
    logic        ld_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_funct3  (ld_funct3),
        .ld_addr_lo (ld_addr_lo),
        .ld_rdata   (ld_rdata),
        .wb_en      (wb_en),
        .rd_index   (rd_index),
        .wb_data    (wb_data),
        .ld_err     (ld_err)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        alu_rd     = 5'd0;
        alu_data   = 32'd0;
        ld_valid   = 1'b0;
        ld_rd      = 5'd0;
        ld_funct3  = F3_LW;
        ld_addr_lo = 2'd0;
        ld_rdata   = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] w);
        ld_valid   = 1'b1;
        ld_rd      = rd;
        ld_funct3  = f3;
        ld_addr_lo = off;
        ld_rdata   = w;
    endtask

    task automatic expect_write(input string name, input logic [4:0] rd,
                                input logic [31:0] d, input logic rdy);
        check({name, " wb_en"}, wb_en, 1'b1);
        check({name, " rd_index"}, rd_index, rd);
        check({name, " wb_data"}, wb_data, d);
        check({name, " alu_ready"}, alu_ready, rdy);
    endtask

    // Reference load formatter: shift the word down by the byte offset,
    // mask to the access size, then extend.
    function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w, output logic bad);
        logic [31:0] b;
        logic [31:0] h;
        b   = (w >> (8 * int'(off))) & 32'h0000_00FF;
        h   = (off >= 2'd2) ? (w >> 16) : (w & 32'h0000_FFFF);
        bad = 1'b0;
        case (f3)
            3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            3'b010:  return w;
            default: begin
                bad = 1'b1;
                return w;
            end
        endcase
    endfunction

    // Reference model state: ALU results waiting behind loads, plus the last
    // value actually written to the register file port.
    wb_entry_t   m_pend [$];
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,          1'b1, 5'd5,  32'h1234_5678, 1'b0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  F3_LB,  2'd3, 32'h80FF_7F01, 1'b1, 5'd7,  32'hFFFF_FF80, 1'b0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  F3_LBU, 2'd3, 32'h80FF_7F01, 1'b1, 5'd7,  32'h0000_0080, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  F3_LH,  2'd2, 32'h80FF_7F01, 1'b1, 5'd7,  32'hFFFF_80FF, 1'b0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  F3_LHU, 2'd1, 32'h80FF_7F01, 1'b1, 5'd7,  32'h0000_7F01, 1'b0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  F3_LW,  2'd2, 32'h80FF_7F01, 1'b1, 5'd7,  32'h80FF_7F01, 1'b0};
        vecs[6] = '{1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,          1'b0, 5'd7,  32'h80FF_7F01, 1'b0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  3'b011, 2'd0, 32'h80FF_7F01, 1'b1, 5'd9,  32'h80FF_7F01, 1'b1};
        vecs[8] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, F3_LB,  2'd1, 32'h80FF_7F01, 1'b1, 5'd10, 32'h0000_007F, 1'b0};
        vecs[9] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 3'b110, 2'd1, 32'h1357_9BDF, 1'b1, 5'd11, 32'h1357_9BDF, 1'b1};

        idle();
        rst_n = 1'b0;
        #2;
        check("reset wb_en", wb_en, 1'b0);
        check("reset rd_index", rd_index, 5'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset ld_err", ld_err, 1'b0);
        check("reset alu_ready", alu_ready, 1'b1);
        check("reset ld_ready", ld_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed single-transaction vectors, each followed by an idle cycle.
        for (int i = 0; i < NV; i++) begin
            idle();
            if (vecs[i].av) set_alu(vecs[i].ard, vecs[i].ad);
            if (vecs[i].lv) set_ld(vecs[i].lrd, vecs[i].f3, vecs[i].off, vecs[i].rdata);
            tick();
            check($sformatf("vec%0d wb_en", i), wb_en, vecs[i].e_en);
            check($sformatf("vec%0d rd_index", i), rd_index, vecs[i].e_rd);
            check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_data);
            check($sformatf("vec%0d ld_err", i), ld_err, vecs[i].e_err);
            check($sformatf("vec%0d alu_ready", i), alu_ready, 1'b1);
            idle();
            tick();
            check($sformatf("vec%0d wb_en pulse", i), wb_en, 1'b0);
            check($sformatf("vec%0d ld_err pulse", i), ld_err, 1'b0);
        end

        // Collision: load and ALU in the same cycle.
        idle();
        set_ld(5'd3, F3_LW, 2'd0, 32'hAAAA_0000);
        set_alu(5'd4, 32'h0000_0055);
        tick();
        expect_write("collide load", 5'd3, 32'hAAAA_0000, 1'b0);
        idle();
        tick();
        expect_write("collide alu", 5'd4, 32'h0000_0055, 1'b1);
        tick();
        check("collide idle wb_en", wb_en, 1'b0);

        // Starvation: buffer full while loads keep arriving.
        idle();
        set_ld(5'd1, F3_LW, 2'd0, 32'h0000_0101);
        set_alu(5'd20, 32'h0000_0077);
        tick();
        expect_write("starve fill", 5'd1, 32'h0000_0101, 1'b0);
        set_alu(5'd21, 32'h0000_0099);
        for (int k = 0; k < 3; k++) begin
            set_ld(5'(k + 2), F3_LW, 2'd0, 32'hC0DE_0000 + k);
            tick();
            expect_write($sformatf("starve load%0d", k), 5'(k + 2), 32'hC0DE_0000 + k, 1'b0);
        end
        ld_valid = 1'b0;
        tick();
        expect_write("starve drain", 5'd20, 32'h0000_0077, 1'b1);
        tick();
        expect_write("starve next alu", 5'd21, 32'h0000_0099, 1'b1);
        idle();
        tick();
        check("starve idle wb_en", wb_en, 1'b0);

        // Async reset with the buffer full, asserted between clock edges.
        set_ld(5'd12, F3_LW, 2'd0, 32'h1111_2222);
        set_alu(5'd13, 32'h3333_4444);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset wb_en", wb_en, 1'b0);
        check("midreset alu_ready", alu_ready, 1'b1);
        check("midreset rd_index", rd_index, 5'd0);
        check("midreset wb_data", wb_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("postreset wb_en%0d", k), wb_en, 1'b0);
            check($sformatf("postreset alu_ready%0d", k), alu_ready, 1'b1);
        end

        // Randomized traffic against the reference model.
        m_rd   = 5'd0;
        m_data = 32'd0;
        for (int c = 0; c < 400; c++) begin
            logic        lv;
            logic        av;
            logic        accept;
            logic        has;
            logic        is_ld;
            logic        bad;
            logic        exp_en;
            wb_entry_t   w;
            wb_entry_t   a;

            idle();
            av = ($urandom_range(0, 9) < 6);
            lv = ($urandom_range(0, 2) == 0);
            a.rd   = 5'($urandom_range(0, 31));
            a.data = $urandom;
            if (av) set_alu(a.rd, a.data);
            if (lv) begin
                logic [2:0] f3;
                logic [4:0] lrd;
                f3  = 3'($urandom_range(0, 7));
                lrd = 5'($urandom_range(0, 31));
                if ((f3 == 3'b011 || f3 >= 3'b110) && lrd == 5'd0) lrd = 5'd1;
                set_ld(lrd, f3, 2'($urandom_range(0, 3)), $urandom);
            end
            #1;
            check($sformatf("rand%0d alu_ready", c), alu_ready, (m_pend.size() == 0));

            accept = av && (m_pend.size() == 0);
            has    = 1'b1;
            is_ld  = 1'b0;
            bad    = 1'b0;
            w      = '0;
            if (lv) begin
                is_ld  = 1'b1;
                w.rd   = ld_rd;
                w.data = ref_align(ld_funct3, ld_addr_lo, ld_rdata, bad);
                if (accept) m_pend.push_back(a);
            end else if (m_pend.size() != 0) begin
                w = m_pend.pop_front();
            end else if (accept) begin
                w = a;
            end else begin
                has = 1'b0;
            end
            exp_en = has && (w.rd != 5'd0);
            if (exp_en) begin
                m_rd   = w.rd;
                m_data = w.data;
            end

            tick();
            check($sformatf("rand%0d wb_en", c), wb_en, exp_en);
            check($sformatf("rand%0d rd_index", c), rd_index, m_rd);
            check($sformatf("rand%0d wb_data", c), wb_data, m_data);
            check($sformatf("rand%0d ld_err", c), ld_err, exp_en && is_ld && bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
